hw_framebuf_axis_rd: RTL and testbench
======================================

# hw_framebuf_axis_rd

Frame-buffer read-out engine for the video interface. It reads a stored frame from the camera frame-buffer block RAM through a read-only port and streams it out as AXI4-Stream video. `tuser` marks start-of-frame and `tlast` marks end-of-line. It is the consumer of the frame buffer that the camera capture path fills, and feeds downstream processing or display logic.

## Interface
Parameters:
- `AWIDTH`, 19: BRAM address width in pixels.
- `DWIDTH`, 16: pixel width (RGB565).
- `H_ACTIVE`, 640: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `RD_LATENCY`, 2: BRAM read latency in cycles; legal values 1 or 2.
- `FIFO_DEPTH`, 4: output buffer entries; must be at least `RD_LATENCY`+2 and a power of two.

Ports:
- `aclk`, in, 1: clock; all logic is in this single domain.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: single-cycle request to read one frame.
- `frame_base`, in, `AWIDTH`: first pixel address; sampled with `frame_start`.
- `busy`, out, 1: high from the accepted start until `done`.
- `done`, out, 1: one-cycle pulse after the last pixel handshake.
- `addr`, out, `AWIDTH`: BRAM address.
- `clk`, out, 1: BRAM clock, driven as `aclk`.
- `en`, out, 1: BRAM read enable.
- `we`, out, 1: BRAM write enable; tied to 0.
- `din`, out, `DWIDTH`: BRAM write data; tied to 0.
- `dout`, in, `DWIDTH`: BRAM read data.
- `m_axis_tdata`, out, `DWIDTH`: pixel data.
- `m_axis_tvalid`, out, 1: pixel valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tuser`, out, 1: start of frame; set on pixel (0,0) only.
- `m_axis_tlast`, out, 1: end of line; set on column `H_ACTIVE`-1.

## Operation
- State machine:
  - IDLE --`frame_start`--> READ: latch `frame_base`; clear the column and line counters.
  - READ --last pixel issued--> DRAIN.
  - DRAIN --FIFO empty and no reads in flight--> IDLE; pulse `done`.
- A `frame_start` that arrives while `busy` is high is ignored. No queuing.
- Read issue happens in READ when (in-flight reads + FIFO occupancy) < `FIFO_DEPTH`. On issue:
  - `en`=1.
  - `addr` = base + pixel index, modulo 2^`AWIDTH` (wraps silently).
  - Column and line counters advance.
- Sideband tracking: a delay line `RD_LATENCY` stages long carries valid, sof and eol flags alongside each read. Entries are written into the FIFO when they emerge, together with `dout`.
- Stream output is driven from the FIFO head.
  - `tdata`, `tuser` and `tlast` are held stable while `tvalid`=1 and `tready`=0.
  - An entry is popped on `tvalid` && `tready`.
- The credit rule guarantees the FIFO never overflows. A FIFO push and pop in the same cycle leaves the count unchanged.
- Counters:
  - column counter is 0..`H_ACTIVE`-1;
  - line counter is 0..`V_ACTIVE`-1;
  - total pixels per frame = `H_ACTIVE`*`V_ACTIVE`.
- Reset mid-frame: all state clears immediately, the FIFO is flushed, and in-flight data is discarded. No `done` is produced.

## Timing
- Reset values:
  - `addr`=0, `en`=0, `we`=0, `din`=0;
  - `busy`=0, `done`=0;
  - `m_axis_tvalid`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
- Start latency: `frame_start` is sampled in cycle T. The first read issues in T+1 and the first `tvalid` rises in T+2+`RD_LATENCY` (T+4 at defaults).
- Throughput: with `tready` held high, one pixel per cycle with no bubbles, including across line boundaries.
- `done` is asserted the cycle after the final handshake. `busy` falls in that same cycle.
- The earliest accepted `frame_start` is the cycle after `done`.

## Configuration
- `HW_FBRD_TPG_EN`
  - When defined: a test pattern replaces `dout` at the FIFO input. `tdata` = {col[4:0], line[5:0], col[4:0]} for RGB565 colour bars. BRAM reads and `en` still occur, so timing is identical.
  - When undefined: `tdata` is the BRAM data. No pattern logic is compiled.

## Test plan
- Default parameters, `tready`=1, `frame_base`=0:
  - 307200 beats;
  - `tuser` only on beat 0;
  - `tlast` on beats 639, 1279, …;
  - `tdata` equals the BRAM contents at each address;
  - `done` one cycle after the last beat.
- `tready` random 50% duty: no lost, duplicated or reordered pixels; `tdata`, `tuser` and `tlast` stable while stalled; FIFO never overflows.
- `frame_base`=2^19-100 with `H_ACTIVE`=16, `V_ACTIVE`=16: addresses wrap to 0 after 2^19-1, and the pixel order is preserved.
- `frame_start` pulsed while `busy`: ignored; exactly one frame is produced.
- `aresetn` asserted at pixel 1000 and released, then a new start: all outputs return to reset values immediately; the new frame begins with `tuser`=1 on pixel 0 and no stale data.
- `RD_LATENCY`=1, `tready`=1, start at T: first `tvalid` in T+3; throughput is one pixel per cycle.

Source files
------------

// File: rtl/hw_framebuf_axis_rd.sv
// ============================================================================
// hw_framebuf_axis_rd
//
// Frame-buffer read-out engine. Reads one stored frame from the camera
// frame-buffer BRAM through a read-only port and streams it out as
// AXI4-Stream video. tuser marks the first pixel of the frame, and tlast
// marks the last pixel of each line.
//
// Ports:
//   aclk, aresetn            clock / asynchronous active-low reset
//   frame_start, frame_base  one-cycle frame request and first pixel address
//   busy, done               frame in progress / one-cycle completion pulse
//   addr, clk, en, we, din   BRAM port (read-only: we and din are tied to 0)
//   dout                     BRAM read data, valid RD_LATENCY cycles after en
//   m_axis_*                 AXI4-Stream video output
//
// Handshake: a beat transfers on any rising aclk edge where tvalid and
// tready are both high. Once tvalid is raised, tvalid, tdata, tuser and tlast
// hold until that transfer happens.
//
// Optional build macro: HW_FBRD_TPG_EN. When it is defined, a colour-bar test
// pattern {col[4:0], line[5:0], col[4:0]} replaces dout at the FIFO input.
// BRAM reads still occur, so the timing does not change.
//
// Debug: the FSM state is exposed on o_dbg_state.
// ============================================================================
module hw_framebuf_axis_rd #(
    parameter int AWIDTH     = 19,
    parameter int DWIDTH     = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              frame_start,
    input  logic [AWIDTH-1:0] frame_base,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] addr,
    output logic              clk,
    output logic              en,
    output logic              we,
    output logic [DWIDTH-1:0] din,
    input  logic [DWIDTH-1:0] dout,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic [1:0]        o_dbg_state
);
    // Counters are at least 5/6 bits wide so the test-pattern slices are legal.
    localparam int CW   = ($clog2(H_ACTIVE) > 5) ? $clog2(H_ACTIVE) : 5;
    localparam int LW   = ($clog2(V_ACTIVE) > 6) ? $clog2(V_ACTIVE) : 6;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t              r_state;
    logic [AWIDTH-1:0]   r_addr;
    logic [CW-1:0]       r_col;
    logic [LW-1:0]       r_line;
    logic                r_busy;
    logic                r_done;

    // Sideband delay line, aligned with the BRAM read pipeline.
    logic [RD_LATENCY-1:0] r_dl_v;
    logic [RD_LATENCY-1:0] r_dl_sof;
    logic [RD_LATENCY-1:0] r_dl_eol;
`ifdef HW_FBRD_TPG_EN
    logic [CW-1:0]         r_dl_col  [RD_LATENCY];
    logic [LW-1:0]         r_dl_line [RD_LATENCY];
`endif

    // Output FIFO
    logic [DWIDTH-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_sof;
    logic [FIFO_DEPTH-1:0] r_fifo_eol;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CNTW-1:0]       r_count;

    logic [CNTW-1:0]       w_inflight;
    logic                  w_issue;
    logic                  w_last_px;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_final;
    logic [DWIDTH-1:0]     w_push_data;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CNTW'(r_dl_v[i]);
        end
    end

    // Credit rule: a read is issued only if it is sure to get a FIFO slot.
    assign w_issue   = (r_state == S_READ) &&
                       ((CNTW+1)'(w_inflight) + (CNTW+1)'(r_count) < (CNTW+1)'(FIFO_DEPTH));
    assign w_last_px = (r_col == CW'(H_ACTIVE-1)) && (r_line == LW'(V_ACTIVE-1));
    assign w_push    = r_dl_v[RD_LATENCY-1];
    assign w_pop     = (r_count != '0) && m_axis_tready;
    // A start arriving in the done cycle is also ignored.
    assign w_start   = frame_start && (r_state == S_IDLE) && !r_done;
    // The last beat leaves when the final entry is popped with nothing left in
    // flight. Finishing on that pop puts done in the very next cycle.
    assign w_final   = (r_state == S_DRAIN) && w_pop && (r_count == CNTW'(1)) &&
                       (w_inflight == '0);

`ifdef HW_FBRD_TPG_EN
    assign w_push_data = DWIDTH'({r_dl_col[RD_LATENCY-1][4:0],
                                  r_dl_line[RD_LATENCY-1][5:0],
                                  r_dl_col[RD_LATENCY-1][4:0]});
`else
    assign w_push_data = dout;
`endif

    // Frame control FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_col   <= '0;
            r_line  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_READ;
                        r_addr  <= frame_base;
                        r_col   <= '0;
                        r_line  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + AWIDTH'(1);
                        if (r_col == CW'(H_ACTIVE-1)) begin
                            r_col  <= '0;
                            r_line <= r_line + LW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_last_px) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_final) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sideband delay line
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_dl_v   <= '0;
            r_dl_sof <= '0;
            r_dl_eol <= '0;
`ifdef HW_FBRD_TPG_EN
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_dl_col[i]  <= '0;
                r_dl_line[i] <= '0;
            end
`endif
        end else begin
            r_dl_v[0]   <= w_issue;
            r_dl_sof[0] <= (r_col == '0) && (r_line == '0);
            r_dl_eol[0] <= (r_col == CW'(H_ACTIVE-1));
`ifdef HW_FBRD_TPG_EN
            r_dl_col[0]  <= r_col;
            r_dl_line[0] <= r_line;
`endif
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_dl_v[i]   <= r_dl_v[i-1];
                r_dl_sof[i] <= r_dl_sof[i-1];
                r_dl_eol[i] <= r_dl_eol[i-1];
`ifdef HW_FBRD_TPG_EN
                r_dl_col[i]  <= r_dl_col[i-1];
                r_dl_line[i] <= r_dl_line[i-1];
`endif
            end
        end
    end

    // Output FIFO. Storage is cleared on reset so that no stale pixel can leak
    // out and tdata reads 0 when the block comes out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_sof <= '0;
            r_fifo_eol <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_sof[r_wr_ptr]  <= r_dl_sof[RD_LATENCY-1];
                r_fifo_eol[r_wr_ptr]  <= r_dl_eol[RD_LATENCY-1];
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign clk           = aclk;
    assign en            = w_issue;
    assign addr          = r_addr;
    assign we            = 1'b0;
    assign din           = '0;
    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tdata  = r_fifo_data[r_rd_ptr];
    assign m_axis_tuser  = m_axis_tvalid && r_fifo_sof[r_rd_ptr];
    assign m_axis_tlast  = m_axis_tvalid && r_fifo_eol[r_rd_ptr];
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_hw_framebuf_axis_rd.sv
// ============================================================================
// tb_hw_framebuf_axis_rd
//
// Bench for hw_framebuf_axis_rd with a small 16x16 frame. The main instance
// uses RD_LATENCY=2, and a second instance uses RD_LATENCY=1. Each instance
// has a behavioural BRAM whose contents are a fixed function of the address.
// The expected beat stream for each frame is built from the frame rules
// (address = base + k mod 2^19, tuser on k==0, tlast on the last column).
// ============================================================================
`timescale 1ns/1ps
module tb_hw_framebuf_axis_rd;
    localparam int AW   = 19;
    localparam int DW   = 16;
    localparam int H    = 16;
    localparam int V    = 16;
    localparam int NPIX = H * V;

    logic          aclk;
    logic          aresetn;

    // main instance (RD_LATENCY = 2)
    logic          frame_start;
    logic [AW-1:0] frame_base;
    logic          busy, done, bram_clk, en, we, tvalid, tready, tuser, tlast;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, dout, tdata;
    logic [1:0]    dbg_state;

    // second instance (RD_LATENCY = 1)
    logic          s1_start;
    logic [AW-1:0] s1_base;
    logic          s1_busy, s1_done, s1_clk, s1_en, s1_we, s1_tvalid, s1_tuser, s1_tlast;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] s1_din, s1_dout, s1_tdata;
    logic [1:0]    s1_dbg_state;

    int n_checks;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- DUTs ----------------
    hw_framebuf_axis_rd #(
        .AWIDTH(AW), .DWIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V),
        .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .frame_start(frame_start), .frame_base(frame_base),
        .busy(busy), .done(done),
        .addr(addr), .clk(bram_clk), .en(en), .we(we), .din(din), .dout(dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .o_dbg_state(dbg_state)
    );

    hw_framebuf_axis_rd #(
        .AWIDTH(AW), .DWIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V),
        .RD_LATENCY(1), .FIFO_DEPTH(4)
    ) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .frame_start(s1_start), .frame_base(s1_base),
        .busy(s1_busy), .done(s1_done),
        .addr(s1_addr), .clk(s1_clk), .en(s1_en), .we(s1_we), .din(s1_din), .dout(s1_dout),
        .m_axis_tdata(s1_tdata), .m_axis_tvalid(s1_tvalid), .m_axis_tready(1'b1),
        .m_axis_tuser(s1_tuser), .m_axis_tlast(s1_tlast),
        .o_dbg_state(s1_dbg_state)
    );

    // ---------------- BRAM models ----------------
    function automatic logic [DW-1:0] bram_val(input logic [AW-1:0] a);
        longint v;
        v = longint'(a);
        return DW'((v * 40503 + (v >> 7) + 17) & 16'hFFFF);
    endfunction

    logic [DW-1:0] p1 = '0, p2 = '0, q1 = '0;
    always @(posedge aclk) begin
        if (en) p1 <= bram_val(addr);
        p2 <= p1;
        if (s1_en) q1 <= bram_val(s1_addr);
    end
    assign dout    = p2;
    assign s1_dout = q1;

    // ---------------- frame runner for the main instance ----------------
    task automatic run_frame(input logic [AW-1:0] base, input int pct, input bit poke, input string tag);
        logic [17:0]   exp_q[$];
        logic [17:0]   exp_beat;
        logic [17:0]   beat;
        logic [17:0]   prev_beat;
        logic [AW-1:0] next_addr;
        logic [AW-1:0] a;
        int            n_issue;
        int            cyc;
        int            first_v;
        int            first_en;
        int            last_hs;
        bit            got_done;
        bit            prev_stall;
        bit            final_seen;
        n_issue = 0; first_v = -1; first_en = -1; last_hs = -1;
        got_done = 0; prev_stall = 0; final_seen = 0; prev_beat = '0;
        next_addr = base;
        for (int k = 0; k < NPIX; k++) begin
            a = AW'((longint'(base) + longint'(k)) % (longint'(1) << AW));
            exp_q.push_back({(k == 0), ((k % H) == H - 1), bram_val(a)});
        end

        @(posedge aclk); #1;
        frame_base  = base;
        frame_start = 1'b1;
        tready      = ($urandom_range(99) < pct);
        @(posedge aclk); #1;
        frame_start = 1'b0;
        tready      = ($urandom_range(99) < pct);
        cyc = 1;
        while (!got_done && cyc < 4000) begin
            @(negedge aclk);
            beat = {tuser, tlast, tdata};
            final_seen = 0;
            if (en) begin
                if (first_en < 0) first_en = cyc;
                n_checks++;
                if (addr !== next_addr) begin
                    n_fail++;
                    $display("FAIL %s addr: got %h expected %h (read %0d)", tag, addr, next_addr, n_issue);
                end
                next_addr = next_addr + AW'(1);
                n_issue++;
            end
            if (prev_stall) begin
                n_checks++;
                if (tvalid !== 1'b1 || beat !== prev_beat) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got v=%b beat=%h expected v=1 beat=%h", tag, tvalid, beat, prev_beat);
                end
            end
            if (tvalid === 1'b1 && first_v < 0) first_v = cyc;
            if (tvalid === 1'b1 && tready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_beat: got %h expected no beat", tag, beat);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (beat !== exp_beat) begin
                        n_fail++;
                        $display("FAIL %s beat %0d: got {user,last,data}=%h expected %h",
                                 tag, NPIX - 1 - exp_q.size(), beat, exp_beat);
                    end
                    if (exp_q.size() == 0) final_seen = 1;
                end
                last_hs = cyc;
            end
            if (done === 1'b1) begin
                got_done = 1;
                n_checks++;
                if (busy !== 1'b0 || last_hs != cyc - 1) begin
                    n_fail++;
                    $display("FAIL %s done_timing: got busy=%b last_hs=%0d at done cyc %0d expected busy=0 last_hs=%0d",
                             tag, busy, last_hs, cyc, cyc - 1);
                end
            end else begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy: got %b expected 1 at cyc %0d", tag, busy, cyc);
                end
            end
            prev_stall = (tvalid === 1'b1) && (tready !== 1'b1);
            prev_beat  = beat;
            if (!got_done) begin
                @(posedge aclk); #1;
                tready      = ($urandom_range(99) < pct);
                frame_start = poke && ((cyc + 1 == 10) || final_seen);
                frame_base  = base + AW'(5);
                cyc++;
            end
        end
        @(posedge aclk); #1;
        frame_start = 1'b0;
        tready      = 1'b1;

        n_checks++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL %s timeout: got no done after %0d cycles expected done", tag, cyc);
        end
        n_checks++;
        if (n_issue != NPIX || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s count: got reads=%0d left=%0d expected reads=%0d left=0", tag, n_issue, exp_q.size(), NPIX);
        end
        n_checks++;
        if (first_en != 1 || first_v != 4) begin
            n_fail++;
            $display("FAIL %s latency: got first_en=%0d first_valid=%0d expected 1 and 4", tag, first_en, first_v);
        end
        if (pct >= 100) begin
            n_checks++;
            if (last_hs - first_v != NPIX - 1) begin
                n_fail++;
                $display("FAIL %s throughput: got span %0d expected %0d", tag, last_hs - first_v, NPIX - 1);
            end
        end
        if (poke) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge aclk);
                n_checks++;
                if (busy !== 1'b0 || tvalid !== 1'b0 || en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ignored_start: got busy=%b tvalid=%b en=%b expected all 0", tag, busy, tvalid, en);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_checks++;
        if ({busy, done, en, we, tvalid, tuser, tlast} !== 7'b0 || addr !== '0 || din !== '0 || tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%b done=%b en=%b we=%b v=%b u=%b l=%b addr=%h din=%h data=%h expected all 0",
                     busy, done, en, we, tvalid, tuser, tlast, addr, din, tdata);
        end
        n_checks++;
        if ({s1_busy, s1_done, s1_en, s1_tvalid} !== 4'b0 || s1_addr !== '0 || s1_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values_lat1: got busy=%b done=%b en=%b v=%b addr=%h data=%h expected all 0",
                     s1_busy, s1_done, s1_en, s1_tvalid, s1_addr, s1_tdata);
        end
    endtask

    task automatic test_full_rate();
        run_frame('0, 100, 0, "full_rate");
    endtask

    task automatic test_random_ready();
        run_frame(AW'($urandom_range(20000)), 50, 0, "random_ready");
    endtask

    task automatic test_wrap();
        run_frame(AW'((1 << AW) - 100), 60, 0, "wrap");
    endtask

    task automatic test_busy_start();
        run_frame(AW'($urandom_range(100000)), 70, 1, "busy_start");
    endtask

    task automatic test_reset_midframe();
        int hs;
        int cyc;
        hs = 0; cyc = 0;
        @(posedge aclk); #1;
        frame_base  = AW'($urandom_range(5000));
        frame_start = 1'b1;
        tready      = 1'b1;
        @(posedge aclk); #1;
        frame_start = 1'b0;
        while (hs < 40 && cyc < 500) begin
            @(negedge aclk);
            if (tvalid === 1'b1) hs++;
            cyc++;
        end
        n_checks++;
        if (hs < 40) begin
            n_fail++;
            $display("FAIL reset_mid_progress: got %0d beats expected 40", hs);
        end
        #2 aresetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, en, tvalid, tuser, tlast} !== 6'b0 || addr !== '0 || tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_values: got busy=%b done=%b en=%b v=%b u=%b l=%b addr=%h data=%h expected all 0",
                     busy, done, en, tvalid, tuser, tlast, addr, tdata);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_checks++;
        if (done !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got done=%b tvalid=%b expected 0", done, tvalid);
        end
        aresetn = 1'b1;
        run_frame(AW'($urandom_range(5000)), 100, 0, "after_reset");
    endtask

    task automatic test_latency1();
        logic [17:0]   exp_q[$];
        logic [17:0]   exp_beat;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        int            cyc;
        int            first_v;
        int            last_hs;
        bit            got_done;
        first_v = -1; last_hs = -1; got_done = 0;
        base = AW'($urandom_range(300000));
        for (int k = 0; k < NPIX; k++) begin
            a = AW'((longint'(base) + longint'(k)) % (longint'(1) << AW));
            exp_q.push_back({(k == 0), ((k % H) == H - 1), bram_val(a)});
        end
        @(posedge aclk); #1;
        s1_base  = base;
        s1_start = 1'b1;
        @(posedge aclk); #1;
        s1_start = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 1000) begin
            @(negedge aclk);
            if (s1_tvalid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL lat1 extra_beat: got %h expected no beat", s1_tdata);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({s1_tuser, s1_tlast, s1_tdata} !== exp_beat) begin
                        n_fail++;
                        $display("FAIL lat1 beat: got %h expected %h", {s1_tuser, s1_tlast, s1_tdata}, exp_beat);
                    end
                end
                last_hs = cyc;
            end
            if (s1_done === 1'b1) got_done = 1;
            if (!got_done) begin
                @(posedge aclk); #1;
                cyc++;
            end
        end
        n_checks++;
        if (!got_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL lat1 completion: got done=%b left=%0d expected done=1 left=0", got_done, exp_q.size());
        end
        n_checks++;
        if (first_v != 3) begin
            n_fail++;
            $display("FAIL lat1 latency: got first_valid=%0d expected 3", first_v);
        end
        n_checks++;
        if (last_hs - first_v != NPIX - 1 || cyc != last_hs + 1) begin
            n_fail++;
            $display("FAIL lat1 throughput: got span=%0d done_cyc=%0d expected span=%0d done_cyc=%0d",
                     last_hs - first_v, cyc, NPIX - 1, last_hs + 1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        aresetn     = 1'b0;
        frame_start = 1'b0;
        frame_base  = '0;
        tready      = 1'b1;
        s1_start    = 1'b0;
        s1_base     = '0;

        test_reset();
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        test_full_rate();
        test_random_ready();
        test_wrap();
        test_busy_start();
        test_reset_midframe();
        test_latency1();
        test_random_ready();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
